// File: rtl/crc8_serial_engine_if.sv
// Byte-stream handshake and CRC result bus for crc8_serial_engine.
// The byte source drives the master side; the engine sits on the slave side.
interface crc8_serial_engine_if;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       crc_valid;
    logic [7:0] crc_out;
    logic       busy;

    modport master (
        output clear, in_valid, in_data, in_last,
        input  in_ready, crc_valid, crc_out, busy
    );

    modport slave (
        input  clear, in_valid, in_data, in_last,
        output in_ready, crc_valid, crc_out, busy
    );
endinterface

// File: rtl/crc8_serial_engine.sv
// Bit-serial CRC-8: folds each accepted byte into the running CRC MSB first,
// one bit per clock, and pulses crc_valid with the final CRC after the last byte.
module crc8_serial_engine #(
    parameter logic [7:0] POLY   = 8'h07,
    parameter logic [7:0] INIT   = 8'h00,
    parameter logic [7:0] XOROUT = 8'h00
) (
    input logic                 clk,
    input logic                 rst,
    crc8_serial_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       last_q, last_d;
    logic       crc_valid_q, crc_valid_d;
    logic [7:0] crc_out_q, crc_out_d;
    logic       fb;
    logic [7:0] crc_shift;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        last_d      = last_q;
        crc_valid_d = 1'b0;
        crc_out_d   = crc_out_q;
        fb          = crc_q[7] ^ shreg_q[7];
        crc_shift   = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d  = bus.in_data;
                    last_d   = bus.in_last;
                    bitcnt_d = 3'd7;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                crc_d   = crc_shift;
                shreg_d = {shreg_q[6:0], 1'b0};
                if (bitcnt_q == 3'd0) begin
                    // The final CRC of the frame is the value being shifted in this cycle.
                    if (last_q) begin
                        state_d     = DONE;
                        crc_valid_d = 1'b1;
                        crc_out_d   = crc_shift ^ XOROUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - 3'd1;
                end
            end
            DONE: begin
                crc_d   = INIT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a byte offered in IDLE.
        if (bus.clear) begin
            state_d     = IDLE;
            crc_d       = INIT;
            shreg_d     = 8'h00;
            bitcnt_d    = 3'd0;
            last_d      = 1'b0;
            crc_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            shreg_q     <= 8'h00;
            bitcnt_q    <= 3'd0;
            last_q      <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_out_q   <= INIT ^ XOROUT;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            last_q      <= last_d;
            crc_valid_q <= crc_valid_d;
            crc_out_q   <= crc_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_out_q;

endmodule

// File: tb/tb_crc8_serial_engine.sv
// Directed bench for crc8_serial_engine (POLY=07, INIT=00, XOROUT=00).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_crc8_serial_engine;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    crc8_serial_engine_if bus ();

    crc8_serial_engine #(
        .POLY  (8'h07),
        .INIT  (8'h00),
        .XOROUT(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame, optionally scrambling the bus while the engine is busy,
    // until the crc_valid pulse (or a cycle budget) and one cycle beyond it.
    task automatic run_frame(input logic [7:0] data [0:15], input int n, input bit bp,
                             output int accepts, output int pulses, output logic [7:0] crc,
                             output bit early, output bit timeout);
        int  idx;
        int  cyc;
        bit  acc_now;
        idx = 0; cyc = 0; accepts = 0; pulses = 0; crc = 8'h00; early = 1'b0;
        while (pulses == 0 && cyc < 400) begin
            if (idx < n) begin
                if (bp && !bus.in_ready) begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.in_data  = 8'($urandom);
                    bus.in_last  = 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = data[idx];
                    bus.in_last  = (idx == n - 1);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc_now) begin
                accepts++;
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (bus.crc_valid) begin
                pulses++;
                crc = bus.crc_out;
                if (idx < n) early = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        timeout = (pulses == 0);
        @(negedge clk);
        if (bus.crc_valid) pulses++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        #2;
        checks++;
        if (bus.crc_valid !== 1'b0 || bus.busy !== 1'b0 || bus.crc_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: crc_valid=%b busy=%b crc_out=%h, required 0 0 00",
                     bus.crc_valid, bus.busy, bus.crc_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    // Single last byte with cycle-by-cycle timing: pulse after E8, ready back after E9.
    task automatic test_single_timing(input logic [7:0] d, input logic [7:0] exp_crc);
        bit bad;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = 1'b1;
        @(posedge clk);
        bad = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (k == 0 || k == 4) bus.in_data = ~d;
            checks++;
            if (bus.crc_valid !== (k == 8) || bus.in_ready !== (k == 9) || bus.busy !== (k != 9)) begin
                errors++; bad = 1'b1;
                $display("FAIL timing_%h_E%0d: crc_valid=%b in_ready=%b busy=%b, required %b %b %b",
                         d, k, bus.crc_valid, bus.in_ready, bus.busy, (k == 8), (k == 9), (k != 9));
            end
            if (k >= 8) begin
                checks++;
                if (bus.crc_out !== exp_crc) begin
                    errors++;
                    $display("FAIL crc_%h_E%0d: crc_out=%h, required %h", d, k, bus.crc_out, exp_crc);
                end
            end
        end
        bus.in_last = 1'b0;
    endtask

    task automatic test_string(input bit bp, input string name);
        logic [7:0] data [0:15];
        int accepts, pulses;
        logic [7:0] crc;
        bit early, timeout;
        for (int i = 0; i < 16; i++) data[i] = 8'h00;
        for (int i = 0; i < 9; i++) data[i] = 8'h31 + 8'(i);
        run_frame(data, 9, bp, accepts, pulses, crc, early, timeout);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL %s_timeout: no crc_valid within budget, required one pulse", name);
        end
        checks++;
        if (accepts !== 9) begin
            errors++;
            $display("FAIL %s_accepts: got %0d, required 9", name, accepts);
        end
        checks++;
        if (pulses !== 1 || early) begin
            errors++;
            $display("FAIL %s_pulses: pulses=%0d early=%b, required 1 0", name, pulses, early);
        end
        checks++;
        if (crc !== 8'hF4) begin
            errors++;
            $display("FAIL %s_crc: crc_out=%h, required f4", name, crc);
        end
    endtask

    task automatic test_clear_abort();
        logic [7:0] data [0:15];
        int accepts, pulses;
        logic [7:0] crc;
        bit early, timeout;
        int n;
        bus.in_valid = 1'b1; bus.in_data = 8'h31; bus.in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL clear_wait_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        bus.in_valid = 1'b1; bus.in_data = 8'h32; bus.in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.crc_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: in_ready=%b busy=%b crc_valid=%b, required 1 0 0",
                     bus.in_ready, bus.busy, bus.crc_valid);
        end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.crc_valid || !bus.in_ready) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL clear_quiet: %0d cycles with activity after abort, required 0", n);
        end
        // Clear together with a byte in IDLE must drop the byte.
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_last = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_blocks_accept: in_ready=%b, required 1", bus.in_ready);
        end
        for (int i = 0; i < 16; i++) data[i] = 8'h00;
        data[0] = 8'h01;
        run_frame(data, 1, 1'b0, accepts, pulses, crc, early, timeout);
        checks++;
        if (timeout || pulses !== 1 || crc !== 8'h07) begin
            errors++;
            $display("FAIL clear_reinit: timeout=%b pulses=%0d crc_out=%h, required 0 1 07",
                     timeout, pulses, crc);
        end
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.crc_valid !== 1'b0 || bus.crc_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b busy=%b crc_valid=%b crc_out=%h, required 1 0 0 00",
                     bus.in_ready, bus.busy, bus.crc_valid, bus.crc_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [0:15];
        int accepts, pulses;
        logic [7:0] crc;
        bit early, timeout;
        for (int i = 0; i < 16; i++) data[i] = 8'h00;
        data[0] = 8'h01;
        run_frame(data, 1, 1'b0, accepts, pulses, crc, early, timeout);
        checks++;
        if (timeout || pulses !== 1 || crc !== 8'h07) begin
            errors++;
            $display("FAIL b2b_first: timeout=%b pulses=%0d crc_out=%h, required 0 1 07", timeout, pulses, crc);
        end
        data[0] = 8'h80;
        run_frame(data, 1, 1'b0, accepts, pulses, crc, early, timeout);
        checks++;
        if (timeout || pulses !== 1 || crc !== 8'h89) begin
            errors++;
            $display("FAIL b2b_second: timeout=%b pulses=%0d crc_out=%h, required 0 1 89", timeout, pulses, crc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_timing(8'h01, 8'h07);
        @(negedge clk);
        test_single_timing(8'h80, 8'h89);
        @(negedge clk);
        test_single_timing(8'h00, 8'h00);
        @(negedge clk);
        test_string(1'b0, "check_string");
        test_string(1'b1, "backpressure");
        test_clear_abort();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_serial_engine.md
Name: crc8_serial_engine

Overview:
Bit-serial CRC-8 generator built from the team's XOR primitive: one feedback XOR plus a polynomial XOR mask per clock.
Accepts a byte stream over a valid/ready handshake and folds each byte into the running CRC, MSB first, over 8 cycles.
On the byte flagged last, it outputs the frame CRC as a one-cycle pulse.
Sits between a byte source (UART RX / packet builder) and the framing/checking logic that appends or compares the CRC.

Parameters:
POLY, 8'h07, generator polynomial without the implicit x^8 term
INIT, 8'h00, CRC register value at reset and at the start of every frame
XOROUT, 8'h00, mask XORed into the CRC register to form crc_out

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous frame abort
in_valid  input  1  in_data/in_last are valid
in_ready  output  1  engine can accept a byte this cycle
in_data  input  8  message byte, processed MSB first
in_last  input  1  byte is the final byte of the frame
crc_valid  output  1  one-cycle pulse; crc_out holds the final frame CRC
crc_out  output  8  CRC register XOR XOROUT, registered
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous, active-high), all outputs and internal registers:
  - state=IDLE, crc=INIT, shreg=0, bitcnt=0, last_q=0.
  - crc_valid=0, crc_out=INIT^XOROUT, busy=0.
  - in_ready=1 once rst deasserts.
- in_ready is combinational: 1 exactly when state==IDLE.
- States:
  - IDLE:
    - On in_valid&&in_ready: shreg<=in_data, last_q<=in_last, bitcnt<=7, go SHIFT.
    - Otherwise hold.
  - SHIFT, one bit per clock:
    - fb = crc[7]^shreg[7].
    - crc <= {crc[6:0],0} ^ (fb ? POLY : 0).
    - shreg <= shreg<<1; bitcnt <= bitcnt-1.
    - On the cycle bitcnt==0: go DONE if last_q, else go IDLE.
  - DONE, exactly one cycle:
    - crc_valid=1; crc_out=crc^XOROUT (registered on entry to DONE).
    - Next edge: crc<=INIT, crc_valid<=0, go IDLE.
- Timing:
  - Byte accepted at edge E0; shifts at edges E1..E8.
  - If last: crc_valid is high between E8 and E9; in_ready returns at E9.
  - Otherwise in_ready returns after E8.
  - Throughput: 9 cycles per byte, plus 1 cycle per frame.
- crc_out holds its last value outside DONE; only the crc_valid pulse qualifies it.
- in_valid while in_ready=0 is ignored: no accept, no side effect. The source must hold the byte until the handshake.
- clear:
  - Beats all other activity in any state: next state IDLE, crc<=INIT, crc_valid<=0, partially shifted byte discarded.
  - clear in IDLE together with in_valid: the byte is NOT accepted.
- Reset mid-frame: immediate return to reset values. No crc_valid is ever produced for the interrupted frame.
- Zero-length frames are not supported; every frame has at least one byte carrying in_last.
- All arithmetic is 8-bit; bitcnt is 3 bits and never wraps (the exit happens at 0).

Test Plan:
1. Reset, then a single byte 8'h01 with in_last, POLY=07, INIT=0 -> crc_valid one cycle at E8–E9 with crc_out=8'h07; in_ready low for cycles E0+..E9.
2. Single byte 8'h80 with in_last -> crc_out=8'h89. Single byte 8'h00 with in_last -> crc_out=8'h00.
3. ASCII "123456789" (8'h31..8'h39), last on 8'h39, in_valid held continuously -> exactly 9 accepts, one crc_valid, crc_out=8'hF4, no crc_valid before the final byte.
4. Backpressure: toggle in_valid and change in_data while in_ready=0 -> CRC is unaffected; the step-3 result is still 8'hF4.
5. Mid-frame abort:
   - Assert clear during SHIFT of byte 2 of a frame -> IDLE next cycle, no crc_valid.
   - Then frame 8'h01 (last) -> 8'h07, proving the CRC was reinitialised.
6. Mid-frame reset:
   - Assert rst asynchronously during SHIFT -> outputs at reset values immediately, before the next clock edge.
   - Two back-to-back frames (8'h01; then 8'h80) -> 8'h07 then 8'h89, with no carry-over between frames.
